// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor: one cipher round per clock, START/DONE level handshake.
// Ciphertext and DONE are registered; the key schedule is expanded on the fly alongside the state.
module aes_encrypt #(
   parameter int NR = 10
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         AES_START,
   input  logic [127:0] AES_KEY,
   input  logic [127:0] AES_MSG_DEC,
   output logic [127:0] AES_MSG_ENC,
   output logic         AES_DONE
);

   if (NR != 10) begin : g_nr_check
      $error("aes_encrypt: only NR=10 (AES-128) is supported");
   end

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[8*(255 - int'(b)) +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   fsm_t         fsm_reg, fsm_next;
   logic [127:0] blk_reg, blk_next;
   logic [127:0] rkey_reg, rkey_next;
   logic [7:0]   rcon_reg, rcon_next;
   logic [3:0]   ctr_reg, ctr_next;
   logic [127:0] enc_reg, enc_next;
   logic         done_reg, done_next;

   logic [7:0]   sub_bytes [16];
   logic [7:0]   shifted [16];
   logic [127:0] shift_flat, mix_flat;

   // Byte i of the 128-bit block lives at bits [127-8i -: 8]; column = i/4, row = i%4.
   for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int COL = gi / 4;
      localparam int ROW = gi % 4;
      assign sub_bytes[gi] = sbox(blk_reg[127 - 8*gi -: 8]);
      assign shifted[gi]   = sub_bytes[4*((COL + ROW) % 4) + ROW];
      assign shift_flat[127 - 8*gi -: 8] = shifted[gi];
      assign mix_flat[127 - 8*gi -: 8] =
         xtime(shifted[4*COL + ROW]) ^ xtime(shifted[4*COL + (ROW + 1) % 4]) ^
         shifted[4*COL + (ROW + 1) % 4] ^ shifted[4*COL + (ROW + 2) % 4] ^
         shifted[4*COL + (ROW + 3) % 4];
   end

   logic [31:0] rot_word, sub_word, key_temp;
   logic [31:0] nk0, nk1, nk2, nk3;
   logic [127:0] next_key;

   assign rot_word = {rkey_reg[23:0], rkey_reg[31:24]};
   for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_word[31 - 8*gi -: 8] = sbox(rot_word[31 - 8*gi -: 8]);
   end
   assign key_temp = sub_word ^ {rcon_reg, 24'h000000};
   assign nk0      = rkey_reg[127:96] ^ key_temp;
   assign nk1      = rkey_reg[95:64] ^ nk0;
   assign nk2      = rkey_reg[63:32] ^ nk1;
   assign nk3      = rkey_reg[31:0] ^ nk2;
   assign next_key = {nk0, nk1, nk2, nk3};

   always_comb begin
      fsm_next  = fsm_reg;
      blk_next  = blk_reg;
      rkey_next = rkey_reg;
      rcon_next = rcon_reg;
      ctr_next  = ctr_reg;
      enc_next  = enc_reg;
      done_next = done_reg;
      case (fsm_reg)
         IDLE: begin
            if (AES_START) begin
               blk_next  = AES_MSG_DEC ^ AES_KEY;
               rkey_next = AES_KEY;
               rcon_next = 8'h01;
               ctr_next  = 4'd1;
               fsm_next  = ROUND;
            end
         end
         ROUND: begin
            blk_next  = mix_flat ^ next_key;
            rkey_next = next_key;
            rcon_next = xtime(rcon_reg);
            ctr_next  = ctr_reg + 4'd1;
            if (ctr_reg == 4'(NR - 1)) begin
               fsm_next = FINAL;
            end
         end
         FINAL: begin
            enc_next  = shift_flat ^ next_key;
            done_next = 1'b1;
            fsm_next  = DONE;
         end
         DONE: begin
            if (!AES_START) begin
               done_next = 1'b0;
               fsm_next  = IDLE;
            end
         end
         default: fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fsm_reg  <= IDLE;
         blk_reg  <= '0;
         rkey_reg <= '0;
         rcon_reg <= '0;
         ctr_reg  <= '0;
         enc_reg  <= '0;
         done_reg <= 1'b0;
      end else begin
         fsm_reg  <= fsm_next;
         blk_reg  <= blk_next;
         rkey_reg <= rkey_next;
         rcon_reg <= rcon_next;
         ctr_reg  <= ctr_next;
         enc_reg  <= enc_next;
         done_reg <= done_next;
      end
   end

   assign AES_MSG_ENC = enc_reg;
   assign AES_DONE    = done_reg;

endmodule

// File: tb/tb_aes_encrypt.sv
// Bench for aes_encrypt: FIPS-197 vectors, handshake/reset corner cases and random plaintexts
// checked against a byte-level AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes_encrypt;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic [127:0] msg_dec;
   logic [127:0] msg_enc;
   logic         done;

   int checks = 0;
   int failures = 0;
   logic [127:0] last_ct;
   logic [7:0]   sbox_m [256];
   logic [7:0]   inv_sbox_m [256];

   localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

   aes_encrypt #(.NR(10)) dut (
      .CLK(clk),
      .RESET(rst),
      .AES_START(start),
      .AES_KEY(key),
      .AES_MSG_DEC(msg_dec),
      .AES_MSG_ENC(msg_enc),
      .AES_DONE(done)
   );

   always #10 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      if (a == 8'h00) return 8'h00;
      for (int x = 1; x < 256; x++) begin
         if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
      end
      return 8'h00;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic void build_sbox();
      logic [7:0] v;
      for (int x = 0; x < 256; x++) begin
         v = ginv(8'(x));
         v = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
         sbox_m[x] = v;
         inv_sbox_m[v] = 8'(x);
      end
   endfunction

   function automatic void expand_key(input logic [127:0] k, output logic [31:0] w [44]);
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
   endfunction

   function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
      logic [31:0] w [44];
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [127:0] out;
      expand_key(k, w);
      for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[4*c + rr] = s[4*((c + rr) % 4) + rr];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               s[4*c + rr] = (r < 10) ?
                  (gmul(8'h02, t[4*c + rr]) ^ gmul(8'h03, t[4*c + (rr+1)%4]) ^
                   t[4*c + (rr+2)%4] ^ t[4*c + (rr+3)%4]) : t[4*c + rr];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
      return out;
   endfunction

   function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
      logic [31:0] w [44];
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [127:0] out;
      expand_key(k, w);
      for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ w[40 + i/4][31 - 8*(i%4) -: 8];
      for (int r = 9; r >= 0; r--) begin
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[4*c + rr] = s[4*((c - rr + 4) % 4) + rr];
         for (int i = 0; i < 16; i++) t[i] = inv_sbox_m[t[i]] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               s[4*c + rr] = (r > 0) ?
                  (gmul(8'h0e, t[4*c + rr]) ^ gmul(8'h0b, t[4*c + (rr+1)%4]) ^
                   gmul(8'h0d, t[4*c + (rr+2)%4]) ^ gmul(8'h09, t[4*c + (rr+3)%4])) : t[4*c + rr];
      end
      for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
      return out;
   endfunction

   // ---------------- helpers ----------------
   task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts one encryption, waits (bounded) for DONE while checking the old ciphertext is held,
   // then checks latency and the result against the model.
   task automatic run_enc(input string tag, input logic [127:0] k, input logic [127:0] p,
                          input bit scramble);
      int lat;
      logic [127:0] exp_ct;
      exp_ct  = model_enc(k, p);
      key     = k;
      msg_dec = p;
      start   = 1'b1;
      tick();
      if (scramble) begin
         key     = '1;
         msg_dec = '1;
      end
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         check128({tag, " hold"}, msg_enc, last_ct);
         tick();
         lat++;
      end
      check128({tag, " latency"}, 128'(lat), 128'd10);
      check128({tag, " ct"}, msg_enc, exp_ct);
      last_ct = exp_ct;
      $display("txn %s key=%h pt=%h ct=%h latency=%0d", tag, k, p, msg_enc, lat);
   endtask

   task automatic release_start(input string tag);
      start = 1'b0;
      tick();
      check128({tag, " done drop"}, 128'(done), 128'd0);
      check128({tag, " ct kept"}, msg_enc, last_ct);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [127:0] rk, rp;
      int extra;
      build_sbox();
      rst = 1'b1;
      start = 1'b0;
      key = '0;
      msg_dec = '0;
      last_ct = '0;
      tick();
      tick();
      check128("reset done", 128'(done), 128'd0);
      check128("reset ct", msg_enc, 128'd0);
      rst = 1'b0;
      tick();

      check128("model C.1", model_enc(KEY1, PT1), CT1);
      check128("model B", model_enc(KEY2, PT2), CT2);

      // FIPS C.1, inputs scrambled to all-ones once the start edge has passed
      run_enc("c1_scrambled", KEY1, PT1, 1'b1);
      check128("c1 fips", msg_enc, CT1);
      check128("c1 roundtrip", model_dec(KEY1, msg_enc), PT1);
      release_start("c1");

      // FIPS App.B with DONE held while START stays high
      run_enc("appb", KEY2, PT2, 1'b0);
      check128("appb fips", msg_enc, CT2);
      for (int i = 0; i < 3; i++) begin
         tick();
         check128("appb done held", 128'(done), 128'd1);
         check128("appb ct held", msg_enc, CT2);
      end
      release_start("appb");

      // Reset during round 5 of vector 1 aborts without output
      key = KEY1;
      msg_dec = PT1;
      start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      start = 1'b0;
      tick();
      check128("abort done", 128'(done), 128'd0);
      check128("abort ct", msg_enc, 128'd0);
      last_ct = '0;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check128("abort no output", 128'(done), 128'd0);
      end
      run_enc("after_abort", KEY2, PT2, 1'b0);
      check128("after_abort fips", msg_enc, CT2);
      release_start("after_abort");

      // Back-to-back: one low cycle of START between two encryptions
      run_enc("b2b_first", KEY1, PT1, 1'b0);
      release_start("b2b_first");
      run_enc("b2b_second", KEY2, PT2, 1'b0);
      check128("b2b second fips", msg_enc, CT2);
      release_start("b2b_second");

      // Random keys/plaintexts with random hold and idle gaps
      for (int n = 0; n < 8; n++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         run_enc($sformatf("rand%0d", n), rk, rp, n[0]);
         extra = int'($urandom_range(0, 2));
         for (int i = 0; i < extra; i++) begin
            tick();
            check128("rand done held", 128'(done), 128'd1);
         end
         release_start($sformatf("rand%0d", n));
         extra = int'($urandom_range(0, 2));
         for (int i = 0; i < extra; i++) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
